// File: rtl/scr1_dmi_ch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scr1_dmi_ch_ctrl
// Purpose  : SysCLK-side DTMCS/DMI scan-chain controller. Owns the chain
//            shift register, drives TDO, and issues single outstanding
//            requests to the Debug Module with sticky busy/error status.
// Revision : 1.0 - initial release
// ============================================================================
module scr1_dmi_ch_ctrl #(
  parameter int DMI_ABITS = 7,
  parameter int DMI_DBITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ch_sel,
  input  logic [1:0]           ch_id,
  input  logic                 ch_capture,
  input  logic                 ch_shift,
  input  logic                 ch_update,
  input  logic                 ch_tdi,
  output logic                 ch_tdo,
  output logic                 dmi_req,
  output logic                 dmi_wr,
  output logic [DMI_ABITS-1:0] dmi_addr,
  output logic [DMI_DBITS-1:0] dmi_wdata,
  input  logic                 dmi_ack,
  input  logic [DMI_DBITS-1:0] dmi_rdata,
  input  logic                 dmi_err,
  output logic                 busy
);

  localparam int         c_SR_W     = DMI_ABITS + DMI_DBITS + 2;
  localparam logic [1:0] c_CH_DTMCS = 2'd0;
  localparam logic [1:0] c_CH_DMI   = 2'd1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;

  logic                   r_cap_d;
  logic                   r_sh_d;
  logic                   r_upd_d;
  logic [c_SR_W-1:0]      r_sr;
  logic                   r_tdo;
  logic                   r_wr;
  logic [DMI_ABITS-1:0]   r_addr;
  logic [DMI_DBITS-1:0]   r_wdata;
  logic [DMI_ABITS-1:0]   r_last_addr;
  logic [DMI_DBITS-1:0]   r_last_rdata;
  logic [1:0]             r_stat;
  logic                   r_discard;

  logic                   w_upd_fire;
  logic                   w_cap_fire;
  logic                   w_sh_fire;
  logic [c_SR_W-1:0]      w_sr_shifted;
  logic [1:0]             w_upd_op;
  logic [DMI_DBITS-1:0]   w_upd_data;
  logic [DMI_ABITS-1:0]   w_upd_addr;

  logic [c_SR_W-1:0]      w_sr_nxt;
  logic                   w_tdo_nxt;
  logic                   w_wr_nxt;
  logic [DMI_ABITS-1:0]   w_addr_nxt;
  logic [DMI_DBITS-1:0]   w_wdata_nxt;
  logic [DMI_ABITS-1:0]   w_last_addr_nxt;
  logic [DMI_DBITS-1:0]   w_last_rdata_nxt;
  logic [1:0]             w_stat_nxt;
  logic                   w_discard_nxt;

  // Rising-edge detection; update wins over capture, capture over shift
  assign w_upd_fire = ch_sel & ch_update  & ~r_upd_d;
  assign w_cap_fire = ch_sel & ch_capture & ~r_cap_d & ~w_upd_fire;
  assign w_sh_fire  = ch_sel & ch_shift   & ~r_sh_d  & ~w_upd_fire & ~w_cap_fire;

  // DMI update fields: {addr, data, op}
  assign w_upd_op   = r_sr[1:0];
  assign w_upd_data = r_sr[DMI_DBITS+1:2];
  assign w_upd_addr = r_sr[c_SR_W-1:DMI_DBITS+2];

  // Shift over the active chain length only; bits above it hold
  always_comb begin
    w_sr_shifted = r_sr;
    case (ch_id)
      c_CH_DTMCS: w_sr_shifted[31:0] = {ch_tdi, r_sr[31:1]};
      c_CH_DMI:   w_sr_shifted       = {ch_tdi, r_sr[c_SR_W-1:1]};
      default:    w_sr_shifted[0]    = ch_tdi;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and datapath: the DM ack is resolved first, then any chain
  // strobe acts on the post-ack view of state, status and last results
  always_comb begin
    w_state_nxt      = r_state;
    w_sr_nxt         = r_sr;
    w_tdo_nxt        = r_tdo;
    w_wr_nxt         = r_wr;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_last_addr_nxt  = r_last_addr;
    w_last_rdata_nxt = r_last_rdata;
    w_stat_nxt       = r_stat;
    w_discard_nxt    = r_discard;

    if ((r_state == ST_REQ) && dmi_ack) begin
      w_state_nxt = ST_IDLE;
      if (r_discard) begin
        w_discard_nxt = 1'b0;
      end else begin
        if (!r_wr) w_last_rdata_nxt = dmi_rdata;
        w_last_addr_nxt = r_addr;
        // A busy (3) status is never downgraded to failed (2)
        if (dmi_err && (r_stat != 2'd3)) w_stat_nxt = 2'd2;
      end
    end

    if (w_upd_fire) begin
      case (ch_id)
        c_CH_DMI: begin
          if (w_state_nxt == ST_REQ) begin
            w_stat_nxt = 2'd3;
          end else if (w_stat_nxt != 2'd0) begin
            w_stat_nxt = w_stat_nxt;
          end else if ((w_upd_op == 2'd1) || (w_upd_op == 2'd2)) begin
            w_addr_nxt  = w_upd_addr;
            w_wdata_nxt = w_upd_data;
            w_wr_nxt    = (w_upd_op == 2'd2);
            w_state_nxt = ST_REQ;
          end
        end
        c_CH_DTMCS: begin
          if (r_sr[17]) begin
            w_stat_nxt = 2'd0;
            if (w_state_nxt == ST_REQ) w_discard_nxt = 1'b1;
          end else if (r_sr[16]) begin
            w_stat_nxt = 2'd0;
          end
        end
        default: ;
      endcase
    end else if (w_cap_fire) begin
      w_tdo_nxt = r_sr[0];
      case (ch_id)
        c_CH_DTMCS: begin
          w_sr_nxt[31:0] = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, w_stat_nxt,
                            6'(DMI_ABITS), 4'd1};
        end
        c_CH_DMI: begin
          if (w_state_nxt == ST_REQ) begin
            w_stat_nxt = 2'd3;
            w_sr_nxt   = {w_last_addr_nxt, w_last_rdata_nxt, 2'd3};
          end else begin
            w_sr_nxt   = {w_last_addr_nxt, w_last_rdata_nxt, w_stat_nxt};
          end
        end
        default: w_sr_nxt[0] = 1'b0;
      endcase
    end else if (w_sh_fire) begin
      w_tdo_nxt = r_sr[0];
      w_sr_nxt  = w_sr_shifted;
    end
  end

  // Strobe history, chain register, request fields and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_d      <= 1'b0;
      r_sh_d       <= 1'b0;
      r_upd_d      <= 1'b0;
      r_sr         <= '0;
      r_tdo        <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_addr  <= '0;
      r_last_rdata <= '0;
      r_stat       <= 2'd0;
      r_discard    <= 1'b0;
    end else begin
      r_cap_d      <= ch_capture;
      r_sh_d       <= ch_shift;
      r_upd_d      <= ch_update;
      r_sr         <= w_sr_nxt;
      r_tdo        <= w_tdo_nxt;
      r_wr         <= w_wr_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_last_addr  <= w_last_addr_nxt;
      r_last_rdata <= w_last_rdata_nxt;
      r_stat       <= w_stat_nxt;
      r_discard    <= w_discard_nxt;
    end
  end

  assign ch_tdo    = r_tdo;
  assign dmi_req   = (r_state == ST_REQ);
  assign busy      = (r_state == ST_REQ);
  assign dmi_wr    = r_wr;
  assign dmi_addr  = r_addr;
  assign dmi_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_scr1_dmi_ch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_dmi_ch_ctrl
// Purpose  : Scoreboard bench for scr1_dmi_ch_ctrl: TDO bits and DM requests
//            are queued by the stimulus and checked by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scr1_dmi_ch_ctrl;

  localparam int AB = 7;
  localparam int DB = 32;
  localparam int SW = AB + DB + 2;

  logic          clk;
  logic          rst;
  logic          ch_sel;
  logic [1:0]    ch_id;
  logic          ch_capture;
  logic          ch_shift;
  logic          ch_update;
  logic          ch_tdi;
  logic          ch_tdo;
  logic          dmi_req;
  logic          dmi_wr;
  logic [AB-1:0] dmi_addr;
  logic [DB-1:0] dmi_wdata;
  logic          dmi_ack;
  logic [DB-1:0] dmi_rdata;
  logic          dmi_err;
  logic          busy;

  scr1_dmi_ch_ctrl #(.DMI_ABITS(AB), .DMI_DBITS(DB)) u_dut (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ch_id(ch_id),
    .ch_capture(ch_capture), .ch_shift(ch_shift), .ch_update(ch_update),
    .ch_tdi(ch_tdi), .ch_tdo(ch_tdo), .dmi_req(dmi_req), .dmi_wr(dmi_wr),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_ack(dmi_ack),
    .dmi_rdata(dmi_rdata), .dmi_err(dmi_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
  } req_t;

  req_t req_q[$];
  logic tdo_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk(input logic [AB-1:0] a, input logic [DB-1:0] d,
                                       input logic [1:0] op);
    return {a, d, op};
  endfunction

  // TDO monitor: one expected bit per accepted shift edge, seen a cycle later
  initial begin
    logic pc, ps, pu, fire;
    pc = 1'b0; ps = 1'b0; pu = 1'b0;
    forever begin
      @(posedge clk);
      fire = !rst && ch_sel && ch_shift && !ps && !(ch_capture && !pc) && !(ch_update && !pu);
      pc = ch_capture; ps = ch_shift; pu = ch_update;
      if (fire) begin
        @(negedge clk);
        if (tdo_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tdo_unexpected: got %0b expected none", ch_tdo);
        end else begin
          chk("tdo_bit", 64'(ch_tdo), 64'(tdo_q.pop_front()));
        end
      end
    end
  end

  // Request monitor: checks each new request and its stability until ack
  initial begin
    req_t e;
    logic pr;
    pr = 1'b0;
    e  = '{wr: 1'b0, addr: '0, wdata: '0};
    forever begin
      @(negedge clk);
      if (dmi_req && !pr) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got addr %0h expected no request", dmi_addr);
        end else begin
          e = req_q.pop_front();
          chk("req_wr",    64'(dmi_wr),    64'(e.wr));
          chk("req_addr",  64'(dmi_addr),  64'(e.addr));
          chk("req_wdata", 64'(dmi_wdata), 64'(e.wdata));
        end
      end else if (dmi_req) begin
        chk("hold_wr",    64'(dmi_wr),    64'(e.wr));
        chk("hold_addr",  64'(dmi_addr),  64'(e.addr));
        chk("hold_wdata", 64'(dmi_wdata), 64'(e.wdata));
      end
      pr = dmi_req;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_cap();
    ch_capture = 1'b1; tick(); ch_capture = 1'b0; tick();
  endtask

  task automatic pulse_sh();
    ch_shift = 1'b1; tick(); ch_shift = 1'b0; tick();
  endtask

  task automatic pulse_upd(input logic exp_req);
    ch_update = 1'b1; tick(); ch_update = 1'b0;
    chk("req_after_update", 64'(dmi_req), 64'(exp_req));
    tick();
  endtask

  task automatic shift_chain(input logic [SW-1:0] din, input logic [SW-1:0] cap, input int len);
    for (int i = 0; i < len; i++) begin
      ch_tdi = din[i];
      tdo_q.push_back(cap[i]);
      pulse_sh();
    end
    ch_tdi = 1'b0;
  endtask

  task automatic do_ack(input logic [DB-1:0] rd, input logic err);
    int n;
    n = 0;
    while (!dmi_req && n < 50) begin tick(); n++; end
    if (!dmi_req) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no request expected dmi_req=1");
    end
    dmi_ack = 1'b1; dmi_rdata = rd; dmi_err = err;
    tick();
    dmi_ack = 1'b0; dmi_rdata = '0; dmi_err = 1'b0;
    chk("busy_after_ack", 64'(busy), 64'd0);
  endtask

  task automatic push_req(input logic wr, input logic [AB-1:0] a, input logic [DB-1:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d;
    req_q.push_back(r);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tdo"},   64'(ch_tdo),    64'd0);
    chk({nm, "_req"},   64'(dmi_req),   64'd0);
    chk({nm, "_wr"},    64'(dmi_wr),    64'd0);
    chk({nm, "_addr"},  64'(dmi_addr),  64'd0);
    chk({nm, "_wdata"}, 64'(dmi_wdata), 64'd0);
    chk({nm, "_busy"},  64'(busy),      64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ch_sel = 1'b1; ch_id = 2'd0; ch_capture = 1'b0; ch_shift = 1'b0;
    ch_update = 1'b0; ch_tdi = 1'b0; dmi_ack = 1'b0; dmi_rdata = '0; dmi_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");

    // DTMCS read: abits 7, idle 1, version 1, dmistat 0
    ch_id = 2'd0; pulse_cap();
    shift_chain('0, {9'b0, 32'h0000_1071}, 32);

    // DMI write, request held without ack for 5 cycles
    ch_id = 2'd1; pulse_cap();
    shift_chain(mk(7'h10, 32'hDEAD_BEEF, 2'd2), '0, SW);
    push_req(1'b1, 7'h10, 32'hDEAD_BEEF);
    pulse_upd(1'b1);
    repeat (5) tick();
    chk("busy_while_req", 64'(busy), 64'd1);
    do_ack(32'hAAAA_AAAA, 1'b0);

    // DMI read of 0x11, then read back the result through the chain
    pulse_cap();
    shift_chain(mk(7'h11, 32'h0, 2'd1), mk(7'h10, 32'h0, 2'd0), SW);
    push_req(1'b0, 7'h11, 32'h0);
    pulse_upd(1'b1);
    do_ack(32'h1234_5678, 1'b0);
    pulse_cap();
    shift_chain(mk(7'h11, 32'h1234_5678, 2'd1), mk(7'h11, 32'h1234_5678, 2'd0), SW);

    // Busy overlap: capture during REQ reports op 3 and makes status sticky
    push_req(1'b0, 7'h11, 32'h1234_5678);
    pulse_upd(1'b1);
    pulse_cap();
    shift_chain(mk(7'h06, 32'hCAFE_F00D, 2'd2), mk(7'h11, 32'h1234_5678, 2'd3), SW);
    pulse_upd(1'b1);
    do_ack(32'h5555_5555, 1'b0);
    pulse_upd(1'b0);
    repeat (3) tick();
    chk("sticky_blocks_req", 64'(busy), 64'd0);
    ch_id = 2'd0; pulse_cap();
    shift_chain({9'b0, 32'h0001_0000}, {9'b0, 32'h0000_1C71}, 32);
    pulse_upd(1'b0);
    ch_id = 2'd1; pulse_cap();
    shift_chain(mk(7'h07, 32'h0, 2'd1), mk(7'h11, 32'h5555_5555, 2'd0), SW);
    push_req(1'b0, 7'h07, 32'h0);
    pulse_upd(1'b1);
    do_ack(32'h0BAD_F00D, 1'b1);

    // Error status, dmireset, then hardreset discards an in-flight result
    ch_id = 2'd0; pulse_cap();
    shift_chain({9'b0, 32'h0001_0000}, {9'b0, 32'h0000_1871}, 32);
    pulse_upd(1'b0);
    ch_id = 2'd1; pulse_cap();
    shift_chain(mk(7'h08, 32'h0, 2'd1), mk(7'h07, 32'h0BAD_F00D, 2'd0), SW);
    push_req(1'b0, 7'h08, 32'h0);
    pulse_upd(1'b1);
    ch_id = 2'd0; pulse_cap();
    shift_chain({9'b0, 32'h0002_0000}, {9'b0, 32'h0000_1071}, 32);
    pulse_upd(1'b1);
    do_ack(32'hFFFF_FFFF, 1'b1);
    ch_id = 2'd1; pulse_cap();
    shift_chain('0, mk(7'h07, 32'h0BAD_F00D, 2'd0), SW);

    // Reset in the middle of a request
    pulse_cap();
    shift_chain(mk(7'h09, 32'h1111_2222, 2'd2), mk(7'h07, 32'h0BAD_F00D, 2'd0), SW);
    push_req(1'b1, 7'h09, 32'h1111_2222);
    pulse_upd(1'b1);
    repeat (2) tick();
    rst = 1'b1; tick();
    chk_all_zero("mid_req_reset");
    rst = 1'b0; tick();

    // Bypass chain, then strobes with ch_sel low leave TDO untouched
    ch_id = 2'd2; pulse_cap();
    ch_tdi = 1'b1; tdo_q.push_back(1'b0); pulse_sh();
    ch_tdi = 1'b0; tdo_q.push_back(1'b1); pulse_sh();
    ch_sel = 1'b0;
    repeat (3) pulse_sh();
    pulse_cap();
    chk("tdo_hold_sel0", 64'(ch_tdo), 64'd1);
    ch_sel = 1'b1;

    repeat (3) tick();
    chk("tdo_q_empty", 64'(tdo_q.size()), 64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
